// File: rtl/agu_pkg.sv
// Shared types and widths for the address-generation unit.
package agu_pkg;

   localparam int unsigned XLEN      = 64;
   localparam int unsigned LS_DISP_W = 16;
   localparam int unsigned BR_DISP_W = 21;

   typedef enum logic {
      SRC_LS = 1'b0,
      SRC_BR = 1'b1
   } agu_src_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_W = 2'd1,
      SZ_L = 2'd2,
      SZ_Q = 2'd3
   } ls_size_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      agu_src_t        src;
      logic            misalign;
   } agu_result_t;

   // Alignment check on the low address bits for a given access size.
   function automatic logic is_misaligned(input logic [2:0] lo, input ls_size_t sz);
      logic mis;
      mis = 1'b0;
      case (sz)
         SZ_B:    mis = 1'b0;
         SZ_W:    mis = lo[0];
         SZ_L:    mis = |lo[1:0];
         SZ_Q:    mis = |lo[2:0];
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/agu_sext.sv
// Sign-extends the memory displacement and the branch displacement (extended, then scaled by 4).
module agu_sext
   import agu_pkg::*;
(
   input  logic [LS_DISP_W-1:0] ls_disp,
   input  logic [BR_DISP_W-1:0] br_disp,
   output logic [XLEN-1:0]      ls_off,
   output logic [XLEN-1:0]      br_off
);

   localparam int unsigned LS_EXT_W = XLEN - LS_DISP_W;
   localparam int unsigned BR_EXT_W = XLEN - BR_DISP_W;

   logic [XLEN-1:0] br_ext;

   assign ls_off = {{LS_EXT_W{ls_disp[LS_DISP_W-1]}}, ls_disp};
   assign br_ext = {{BR_EXT_W{br_disp[BR_DISP_W-1]}}, br_disp};
   assign br_off = XLEN'(br_ext << 2);

endmodule

// File: rtl/agu_arbiter.sv
// Round-robin arbiter between load/store and branch requesters sharing one 64-bit adder,
// with a single registered result slot.
module agu_arbiter
   import agu_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ls_valid,
   output logic                 ls_ready,
   input  logic [XLEN-1:0]      ls_base,
   input  logic [LS_DISP_W-1:0] ls_disp,
   input  logic [1:0]           ls_size,
   input  logic                 br_valid,
   output logic                 br_ready,
   input  logic [XLEN-1:0]      br_pc,
   input  logic [BR_DISP_W-1:0] br_disp,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_addr,
   output logic                 out_src,
   output logic                 out_misalign
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   agu_result_t     res_q, res_d;
   agu_src_t        last_q, last_d;

   logic [XLEN-1:0] ls_off, br_off;
   logic [XLEN-1:0] op_a, op_b, sum;
   logic            slot_free, can_grant, ls_wins, grant_ls, grant_br;

   agu_sext u_sext (
      .ls_disp (ls_disp),
      .br_disp (br_disp),
      .ls_off  (ls_off),
      .br_off  (br_off)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         res_q   <= '0;
         last_q  <= SRC_BR;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         last_q  <= last_d;
      end
   end

   // Grant selection, shared adder and next-state for the result slot.
   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      last_d    = last_q;
      slot_free = (state_q == ST_EMPTY) || out_ready;
      can_grant = slot_free && !flush;
      ls_wins   = ls_valid && (!br_valid || (last_q == SRC_BR));
      grant_ls  = can_grant && ls_wins;
      grant_br  = can_grant && br_valid && !ls_wins;
      op_a      = grant_br ? br_pc  : ls_base;
      op_b      = grant_br ? br_off : ls_off;
      sum       = op_a + op_b;

      if (flush) begin
         state_d = ST_EMPTY;
      end else if (grant_ls || grant_br) begin
         state_d        = ST_FULL;
         res_d.addr     = sum;
         res_d.src      = grant_br ? SRC_BR : SRC_LS;
         res_d.misalign = grant_ls && is_misaligned(sum[2:0], ls_size_t'(ls_size));
         last_d         = grant_br ? SRC_BR : SRC_LS;
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   assign ls_ready     = grant_ls;
   assign br_ready     = grant_br;
   assign out_valid    = (state_q == ST_FULL);
   assign out_addr     = res_q.addr;
   assign out_src      = res_q.src;
   assign out_misalign = res_q.misalign;

endmodule

// File: tb/tb_agu_arbiter.sv
// Directed bench for agu_arbiter with hand-computed expected addresses and grant order.
module tb_agu_arbiter;

   logic        clk;
   logic        reset;
   logic        ls_valid, ls_ready;
   logic [63:0] ls_base;
   logic [15:0] ls_disp;
   logic [1:0]  ls_size;
   logic        br_valid, br_ready;
   logic [63:0] br_pc;
   logic [20:0] br_disp;
   logic        flush;
   logic        out_valid, out_ready;
   logic [63:0] out_addr;
   logic        out_src, out_misalign;

   int vectors;
   int miscompares;

   agu_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .ls_valid     (ls_valid),
      .ls_ready     (ls_ready),
      .ls_base      (ls_base),
      .ls_disp      (ls_disp),
      .ls_size      (ls_size),
      .br_valid     (br_valid),
      .br_ready     (br_ready),
      .br_pc        (br_pc),
      .br_disp      (br_disp),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_addr     (out_addr),
      .out_src      (out_src),
      .out_misalign (out_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ls_valid = 1'b1; br_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      vectors++;
      if (out_addr !== 64'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", out_addr); end
      vectors++;
      if ({out_src, out_misalign} !== 2'b00) begin miscompares++; $display("FAIL reset_src_mis: got %b expected 00", {out_src, out_misalign}); end
      vectors++;
      if ({ls_ready, br_ready} !== 2'b10) begin miscompares++; $display("FAIL reset_ready: got %b expected 10", {ls_ready, br_ready}); end
      ls_valid = 1'b0;
      reset = 1'b0;
      step();
   endtask

   task automatic test_ls_sext();
      ls_valid = 1'b1; br_valid = 1'b0; out_ready = 1'b1;
      ls_base = 64'h1000; ls_disp = 16'hFFF8; ls_size = 2'd3;
      #1;
      vectors++;
      if (ls_ready !== 1'b1) begin miscompares++; $display("FAIL ls_ready: got %b expected 1", ls_ready); end
      step();
      vectors++;
      if ({out_valid, out_addr, out_src, out_misalign} !== {1'b1, 64'hFF8, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL ls_neg_disp: got v=%b a=%h s=%b m=%b expected v=1 a=ff8 s=0 m=0", out_valid, out_addr, out_src, out_misalign);
      end
      ls_disp = 16'h0004;
      step();
      vectors++;
      if ({out_valid, out_addr, out_misalign} !== {1'b1, 64'h1004, 1'b1}) begin
         miscompares++; $display("FAIL ls_misalign: got v=%b a=%h m=%b expected v=1 a=1004 m=1", out_valid, out_addr, out_misalign);
      end
      ls_disp = 16'h0002; ls_size = 2'd1;
      step();
      vectors++;
      if ({out_addr, out_misalign} !== {64'h1002, 1'b0}) begin
         miscompares++; $display("FAIL ls_word_align: got a=%h m=%b expected a=1002 m=0", out_addr, out_misalign);
      end
      ls_valid = 1'b0;
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ls_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_br_shift();
      br_valid = 1'b1; ls_valid = 1'b0; out_ready = 1'b1;
      br_pc = 64'h2004; br_disp = 21'h1FFFFF;
      #1;
      vectors++;
      if ({ls_ready, br_ready} !== 2'b01) begin miscompares++; $display("FAIL br_ready: got %b expected 01", {ls_ready, br_ready}); end
      step();
      vectors++;
      if ({out_valid, out_addr, out_src, out_misalign} !== {1'b1, 64'h2000, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL br_neg_disp: got v=%b a=%h s=%b m=%b expected v=1 a=2000 s=1 m=0", out_valid, out_addr, out_src, out_misalign);
      end
      br_disp = 21'h0FFFFF;
      step();
      vectors++;
      if (out_addr !== 64'h402000) begin miscompares++; $display("FAIL br_pos_disp: got %h expected 402000", out_addr); end
      br_valid = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_src;
      exp_src = 4'b1010;
      do_reset();
      ls_valid = 1'b1; br_valid = 1'b1; out_ready = 1'b1;
      ls_base = 64'h100; ls_disp = 16'h0; ls_size = 2'd0;
      br_pc = 64'h200; br_disp = 21'h0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if ({ls_ready, br_ready} !== {~exp_src[i], exp_src[i]}) begin
            miscompares++; $display("FAIL rr_ready_%0d: got %b expected %b", i, {ls_ready, br_ready}, {~exp_src[i], exp_src[i]});
         end
         step();
         vectors++;
         if ({out_valid, out_src} !== {1'b1, exp_src[i]}) begin
            miscompares++; $display("FAIL rr_out_%0d: got v=%b s=%b expected v=1 s=%b", i, out_valid, out_src, exp_src[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      // Slot holds the branch result (0x200); both requesters stay valid.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if ({ls_ready, br_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_ready_%0d: got %b expected 00", i, {ls_ready, br_ready}); end
         step();
         vectors++;
         if ({out_valid, out_addr, out_src} !== {1'b1, 64'h200, 1'b1}) begin
            miscompares++; $display("FAIL bp_hold_%0d: got v=%b a=%h s=%b expected v=1 a=200 s=1", i, out_valid, out_addr, out_src);
         end
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if ({ls_ready, br_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 10", {ls_ready, br_ready}); end
      step();
      vectors++;
      if ({out_valid, out_addr, out_src} !== {1'b1, 64'h100, 1'b0}) begin
         miscompares++; $display("FAIL bp_release_out: got v=%b a=%h s=%b expected v=1 a=100 s=0", out_valid, out_addr, out_src);
      end
   endtask

   task automatic test_flush();
      // Slot is FULL with a load/store result, so branch should win the next tie.
      br_valid = 1'b0; ls_valid = 1'b1; out_ready = 1'b0; flush = 1'b1;
      #1;
      vectors++;
      if ({ls_ready, br_ready} !== 2'b00) begin miscompares++; $display("FAIL flush_ready: got %b expected 00", {ls_ready, br_ready}); end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
      flush = 1'b0; br_valid = 1'b1; out_ready = 1'b1;
      #1;
      vectors++;
      if ({ls_ready, br_ready} !== 2'b01) begin miscompares++; $display("FAIL flush_last_grant: got %b expected 01", {ls_ready, br_ready}); end
      step();
      vectors++;
      if ({out_valid, out_src} !== 2'b11) begin miscompares++; $display("FAIL flush_after: got %b expected 11", {out_valid, out_src}); end
      br_valid = 1'b0; ls_valid = 1'b0;
      step();
   endtask

   task automatic test_wrap_reset();
      ls_valid = 1'b1; br_valid = 1'b0; out_ready = 1'b1;
      ls_base = 64'hFFFF_FFFF_FFFF_FFFC; ls_disp = 16'h0008; ls_size = 2'd2;
      step();
      vectors++;
      if ({out_valid, out_addr, out_misalign} !== {1'b1, 64'h4, 1'b0}) begin
         miscompares++; $display("FAIL wrap_addr: got v=%b a=%h m=%b expected v=1 a=4 m=0", out_valid, out_addr, out_misalign);
      end
      // Hold FULL, then pulse reset between edges.
      ls_valid = 1'b0; out_ready = 1'b0;
      step();
      #1 reset = 1'b1;
      #1;
      vectors++;
      if ({out_valid, out_addr} !== {1'b0, 64'h0}) begin
         miscompares++; $display("FAIL async_reset: got v=%b a=%h expected v=0 a=0", out_valid, out_addr);
      end
      #1 reset = 1'b0;
      ls_valid = 1'b1; br_valid = 1'b1; out_ready = 1'b1;
      ls_base = 64'h300; ls_disp = 16'h0;
      #1;
      vectors++;
      if ({ls_ready, br_ready} !== 2'b10) begin miscompares++; $display("FAIL post_reset_tie: got %b expected 10", {ls_ready, br_ready}); end
      step();
      vectors++;
      if ({out_valid, out_addr, out_src} !== {1'b1, 64'h300, 1'b0}) begin
         miscompares++; $display("FAIL post_reset_out: got v=%b a=%h s=%b expected v=1 a=300 s=0", out_valid, out_addr, out_src);
      end
      ls_valid = 1'b0; br_valid = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      ls_valid = 1'b0; ls_base = '0; ls_disp = '0; ls_size = '0;
      br_valid = 1'b0; br_pc = '0; br_disp = '0;
      test_reset();
      test_ls_sext();
      test_br_shift();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_wrap_reset();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/agu_arbiter.md
# agu_arbiter

Shared address-generation unit for the 64-bit core: sign-extends and adds load/store and branch offsets on one time-shared 64-bit adder. Arbitrates between the load/store requester and the branch requester with valid/ready handshakes and round-robin priority. Registers one result per cycle toward the memory stage or the fetch redirect logic.

## Interface
- No parameters; widths are fixed by the ISA (64-bit data, 16-bit memory displacement, 21-bit branch displacement).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ls_valid` in 1: load/store request present.
- `ls_ready` out 1: load/store request accepted this cycle.
- `ls_base` in 64: base register value.
- `ls_disp` in 16: memory displacement, two's complement.
- `ls_size` in 2: access size; 0=byte, 1=word, 2=long, 3=quad.
- `br_valid` in 1: branch target request present.
- `br_ready` out 1: branch request accepted this cycle.
- `br_pc` in 64: updated PC (branch PC + 4).
- `br_disp` in 21: branch displacement in instructions, two's complement.
- `flush` in 1: synchronous pipeline flush.
- `out_valid` out 1: result register holds a valid result.
- `out_ready` in 1: consumer accepts the result.
- `out_addr` out 64: computed address.
- `out_src` out 1: source of the result; 0=load/store, 1=branch.
- `out_misalign` out 1: load/store address not aligned to `ls_size`; always 0 for branch results.

## Operation
- Arithmetic:
  - Load/store: `ls_base + sext64(ls_disp)`, where the sign is bit 15.
  - Branch: `br_pc + (sext64(br_disp) << 2)`, where the sign is bit 20 and the shift happens after extension.
  - Sums wrap modulo 2^64; there is no overflow flag.
- Misalignment:
  - size 0: never misaligned.
  - size 1: addr[0] != 0.
  - size 2: addr[1:0] != 0.
  - size 3: addr[2:0] != 0.
- Slot free = `!out_valid || out_ready`.
- Grant is issued only when the slot is free and `flush` = 0.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the source not granted last (`last_grant` flop; reset value = branch, so load/store wins the first tie).
  - `last_grant` updates only on an actual grant.
- At most one of `ls_ready`/`br_ready` is high in any cycle.
- Ready outputs are combinational from the valids, slot-free, `flush` and `last_grant`.
- A requester may drop its valid without being granted (no hold requirement on requesters).
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on `out_ready` with a grant (back-to-back, new result loaded).
  - FULL -> EMPTY on `out_ready` without a grant.
  - FULL holds all fields stable while `out_ready`=0.
- `flush`:
  - Next state is EMPTY regardless of `out_ready`.
  - No grant in the flush cycle.
  - `last_grant` is unchanged.
- Reset values:
  - `out_valid`=0, `out_addr`=0, `out_src`=0, `out_misalign`=0.
  - `last_grant`=branch.
  - `ls_ready`/`br_ready` follow the combinational rule (high when the corresponding valid is present, since the slot is free).

## Timing
- Latency is 1 cycle: a request accepted at edge N appears with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput is 1 result per cycle while `out_ready`=1.
- Backpressure: with FULL and `out_ready`=0, both readies are 0. The alternating round-robin order resumes when the stall releases.
- Reset asserted mid-operation:
  - Registered outputs go to reset values immediately, without waiting for `clk`.
  - An in-flight result is discarded.
- Reset deassertion is synchronized externally; the block assumes the release meets recovery timing.

## Structure
- Shared package `agu_pkg`:
  - `XLEN`=64, `LS_DISP_W`=16, `BR_DISP_W`=21.
  - Enum `agu_src_t` {SRC_LS, SRC_BR}.
  - Enum `ls_size_t` {SZ_B, SZ_W, SZ_L, SZ_Q}.
- One sub-module: `agu_sext`, a combinational sign-extender producing both extended offsets (memory displacement unshifted, branch displacement extended then shifted left 2).
- The adder, arbiter and output register live in `agu_arbiter`.

## Test plan
- Load/store sign extension: `ls_base`=0x1000, `ls_disp`=0xFFF8, size 3 -> next cycle `out_addr`=0xFF8, `out_src`=0, `out_misalign`=0. Then `ls_disp`=0x0004, size 3 -> `out_addr`=0x1004, `out_misalign`=1.
- Branch extend-then-shift: `br_pc`=0x2004, `br_disp`=0x1FFFFF -> `out_addr`=0x2000. Then `br_disp`=0x0FFFFF -> `out_addr`=0x2004+0x3FFFFC=0x402000.
- Round-robin under contention: both valid continuously, `out_ready`=1 for 4 cycles from reset -> grant order LS, BR, LS, BR; `out_valid` high on 4 consecutive cycles.
- Backpressure: FULL with `out_ready`=0 for 3 cycles -> `ls_ready`=`br_ready`=0 and `out_addr` stable. Release -> held result consumed and the pending request granted the same cycle.
- Flush: FULL with `flush`=1 and `ls_valid`=1 -> `ls_ready`=0, `out_valid`=0 next cycle, `last_grant` unchanged.
- Wrap-around and async reset:
  - `ls_base`=0xFFFF_FFFF_FFFF_FFFC, `ls_disp`=0x0008 -> `out_addr`=0x4.
  - `reset` pulsed between clock edges while FULL -> `out_valid`=0 immediately; first tie after reset grants LS.
